// File: rtl/mem_xfer_ctrl.sv
// rtl/mem_xfer_ctrl.sv - loads DEPTH words into bank A, then copies A to bank B
// Optional MEM_XFER_SKIP_ZERO_EN: zero words read from A are dropped instead of copied.
module mem_xfer_ctrl #(
  parameter int DW    = 8,
  parameter int AW    = 2,
  parameter int DEPTH = 4
) (
  input  logic          clock,
  input  logic          Reset,
  input  logic          Start,
  input  logic [DW-1:0] DataIn,
  input  logic          DataInValid,
  output logic          DataInReady,
  output logic          WEA,
  output logic [AW-1:0] AddrA,
  output logic [DW-1:0] DataOutA,
  input  logic [DW-1:0] RdDataA,
  output logic          WEB,
  output logic [AW-1:0] AddrB,
  output logic [DW-1:0] DataOutB,
  output logic          Busy,
  output logic          Done,
  output logic [AW:0]   CountB
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_RD,
    S_WR,
    S_DONE
  } state_t;

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  state_t        r_state;
  logic [AW-1:0] r_fill_cnt;
  logic [AW-1:0] r_rd_cnt;
  logic [AW-1:0] r_b_cnt;
  logic [AW:0]   r_count_b;
  logic [DW-1:0] r_hold;
  logic          w_skip;

`ifdef MEM_XFER_SKIP_ZERO_EN
  assign w_skip = (RdDataA == '0);
`else
  assign w_skip = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (!Reset) begin
      r_state    <= S_IDLE;
      r_fill_cnt <= '0;
      r_rd_cnt   <= '0;
      r_b_cnt    <= '0;
      r_count_b  <= '0;
      r_hold     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (Start) begin
            r_state    <= S_FILL;
            r_fill_cnt <= '0;
            r_rd_cnt   <= '0;
            r_b_cnt    <= '0;
            r_count_b  <= '0;
          end
        end
        S_FILL: begin
          if (DataInValid) begin
            r_fill_cnt <= r_fill_cnt + AW'(1);
            if (r_fill_cnt == LAST) begin
              r_state  <= S_RD;
              r_rd_cnt <= '0;
            end
          end
        end
        S_RD: begin
          // A dropped word skips WR entirely, so B stays densely packed.
          if (w_skip) begin
            r_rd_cnt <= r_rd_cnt + AW'(1);
            r_state  <= (r_rd_cnt == LAST) ? S_DONE : S_RD;
          end else begin
            r_hold  <= RdDataA;
            r_state <= S_WR;
          end
        end
        S_WR: begin
          r_b_cnt   <= r_b_cnt + AW'(1);
          r_count_b <= r_count_b + (AW+1)'(1);
          r_rd_cnt  <= r_rd_cnt + AW'(1);
          r_state   <= (r_rd_cnt == LAST) ? S_DONE : S_RD;
        end
        S_DONE: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign DataInReady = (r_state == S_FILL);
  assign WEA         = DataInReady && DataInValid;
  assign DataOutA    = WEA ? DataIn : '0;

  always_comb begin
    AddrA = '0;
    if (r_state == S_FILL) begin
      AddrA = r_fill_cnt;
    end else if (r_state == S_RD || r_state == S_WR) begin
      AddrA = r_rd_cnt;
    end
  end

  assign WEB      = (r_state == S_WR);
  assign AddrB    = WEB ? r_b_cnt : '0;
  assign DataOutB = WEB ? r_hold : '0;
  assign Busy     = (r_state != S_IDLE);
  assign Done     = (r_state == S_DONE);
  assign CountB   = r_count_b;

endmodule

// File: tb/tb_mem_xfer_ctrl.sv
// tb/tb_mem_xfer_ctrl.sv - self-checking bench for mem_xfer_ctrl
module tb_mem_xfer_ctrl;
  localparam int DW = 8;
  localparam int AW = 2;
  localparam int DEPTH = 4;

  logic          clock = 1'b0;
  logic          Reset;
  logic          Start;
  logic [DW-1:0] DataIn;
  logic          DataInValid;
  logic          DataInReady;
  logic          WEA;
  logic [AW-1:0] AddrA;
  logic [DW-1:0] DataOutA;
  logic [DW-1:0] RdDataA;
  logic          WEB;
  logic [AW-1:0] AddrB;
  logic [DW-1:0] DataOutB;
  logic          Busy;
  logic          Done;
  logic [AW:0]   CountB;

  always #5 clock = ~clock;

  mem_xfer_ctrl #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) dut (
    .clock(clock), .Reset(Reset), .Start(Start),
    .DataIn(DataIn), .DataInValid(DataInValid), .DataInReady(DataInReady),
    .WEA(WEA), .AddrA(AddrA), .DataOutA(DataOutA), .RdDataA(RdDataA),
    .WEB(WEB), .AddrB(AddrB), .DataOutB(DataOutB),
    .Busy(Busy), .Done(Done), .CountB(CountB)
  );

  logic [DW-1:0] mem_a [DEPTH];
  logic [DW-1:0] mem_b [DEPTH];
  assign RdDataA = mem_a[AddrA];
  always @(posedge clock) begin
    if (WEA) mem_a[AddrA] <= DataOutA;
    if (WEB) mem_b[AddrB] <= DataOutB;
  end

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int c;
    int addr;
    int data;
  } ev_t;

  ev_t exp_a[$];
  ev_t exp_rd[$];
  ev_t exp_b[$];

  int n_checks = 0;
  int n_errors = 0;
  int fill_lo = -1, fill_hi = -1, busy_lo = -1, busy_hi = -1;
  int exp_done = -1, exp_count = 0, last_done = -1;
  int zero_lo = 1, zero_hi = 3;
  int s0;
  logic [DW-1:0] xw [DEPTH];

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic compare_cycle();
    bit  in_fill;
    bit  exp_web;
    ev_t e;
    if (cyc >= zero_lo && cyc <= zero_hi)
      check("reset_outputs", {DataInReady, WEA, WEB, Busy, Done, AddrA, AddrB,
                              DataOutA, DataOutB, CountB}, 0);
    in_fill = (cyc >= fill_lo) && (cyc <= fill_hi);
    check("ready", DataInReady, in_fill);
    check("wea", WEA, in_fill && DataInValid);
    check("busy", Busy, (cyc >= busy_lo) && (cyc <= busy_hi));
    check("done", Done, cyc == exp_done);
    check("we_exclusive", WEA && WEB, 0);
    if (Done) begin
      last_done = cyc;
      check("countb_done", CountB, exp_count);
    end
    if (cyc == fill_lo) check("countb_cleared", CountB, 0);
    if (WEA) begin
      if (exp_a.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL wea_unexpected at cycle %0d: got write addr %0h data %0h expected none",
                 cyc, AddrA, DataOutA);
      end else begin
        e = exp_a.pop_front();
        check("addr_a_wr", AddrA, e.addr);
        check("data_out_a", DataOutA, e.data);
      end
    end
    if (exp_rd.size() > 0 && exp_rd[0].c == cyc) begin
      e = exp_rd.pop_front();
      check("addr_a_rd", AddrA, e.addr);
    end
    exp_web = (exp_b.size() > 0) && (exp_b[0].c == cyc);
    check("web", WEB, exp_web);
    if (exp_web) begin
      e = exp_b.pop_front();
      check("addr_b", AddrB, e.addr);
      check("data_out_b", DataOutB, e.data);
      check("countb_wr", CountB, e.addr);
    end
  endtask

  // Called in cycle s with the controller idle; Start is raised in cycle s.
  task automatic run_xfer(input int stall, input int pulse_at, input int rst_wr,
                          input bit hold_end);
    int s, t, k, d, r, c0;
    bit drop;
    s  = cyc;
    c0 = s + 1 + DEPTH + stall;
    t  = c0;
    k  = 0;
    r  = -1;
    for (int i = 0; i < DEPTH; i++) begin
      drop = 1'b0;
`ifdef MEM_XFER_SKIP_ZERO_EN
      drop = (xw[i] == '0);
`endif
      exp_rd.push_back('{t, i, 0});
      if (drop) begin
        t += 1;
      end else begin
        exp_b.push_back('{t + 1, k, int'(xw[i])});
        k++;
        if (k == rst_wr) r = t + 1;
        t += 2;
      end
    end
    d = t;
    fill_lo = s + 1;
    fill_hi = s + DEPTH + stall;
    busy_lo = s + 1;
    busy_hi = d;
    exp_done = d;
    exp_count = k;
    if (r >= 0) begin
      while (exp_b.size() > 0 && exp_b[exp_b.size()-1].c > r) void'(exp_b.pop_back());
      while (exp_rd.size() > 0 && exp_rd[exp_rd.size()-1].c > r) void'(exp_rd.pop_back());
      busy_hi = r;
      exp_done = -1;
      zero_lo = r + 1;
      zero_hi = r + 1;
    end

    Start = 1'b1;
    step();
    Start = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (i == 2) begin
        for (int j = 0; j < stall; j++) begin
          DataInValid = 1'b0;
          DataIn = DW'($urandom);
          step();
        end
      end
      DataIn = xw[i];
      DataInValid = 1'b1;
      exp_a.push_back('{cyc, i, int'(xw[i])});
      step();
    end
    DataInValid = 1'b0;
    DataIn = 8'hA5;

    while (cyc < ((r >= 0) ? r : d)) begin
      Start = (pulse_at >= 0 && cyc >= c0 + pulse_at && cyc <= c0 + pulse_at + 1);
      step();
    end
    Start = 1'b0;
    if (r >= 0) begin
      Reset = 1'b0;
      step();
      Reset = 1'b1;
      step();
      step();
    end else begin
      if (hold_end) Start = 1'b1;
      step();
    end
  endtask

  initial begin
    Reset = 1'b0;
    Start = 1'b1;
    DataIn = '0;
    DataInValid = 1'b0;
    fork
      forever begin
        @(negedge clock);
        if (cyc > 0) compare_cycle();
      end
    join_none
    repeat (3) step();
    Reset = 1'b1;

    xw = '{8'h11, 8'h22, 8'h33, 8'h44};
    s0 = cyc;
    run_xfer(0, -1, -1, 1'b0);
    check("basic_latency", last_done - s0, 13);
    check("basic_b0", mem_b[0], 8'h11);
    check("basic_b1", mem_b[1], 8'h22);
    check("basic_b2", mem_b[2], 8'h33);
    check("basic_b3", mem_b[3], 8'h44);
    check("basic_countb", CountB, 4);
    step();

    xw = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    s0 = cyc;
    run_xfer(5, -1, -1, 1'b0);
    check("stall_latency", last_done - s0, 18);
    check("stall_b2", mem_b[2], 8'hC3);
    step();

    xw = '{8'h55, 8'h66, 8'h77, 8'h88};
    s0 = cyc;
    run_xfer(0, 1, -1, 1'b0);
    check("pulse_latency", last_done - s0, 13);
    check("pulse_b3", mem_b[3], 8'h88);
    step();

    xw = '{8'h01, 8'h02, 8'h03, 8'h04};
    run_xfer(0, -1, -1, 1'b1);
    xw = '{8'h9A, 8'hBC, 8'hDE, 8'hF0};
    s0 = cyc;
    run_xfer(0, -1, -1, 1'b0);
    check("rearm_latency", last_done - s0, 13);
    check("rearm_b0", mem_b[0], 8'h9A);
    step();

    xw = '{8'h21, 8'h43, 8'h65, 8'h87};
    run_xfer(0, -1, 2, 1'b0);
    check("midrst_busy", Busy, 0);
    check("midrst_web", WEB, 0);
    check("midrst_countb", CountB, 0);
    check("midrst_b1", mem_b[1], 8'h43);

    xw = '{8'h3C, 8'h4D, 8'h5E, 8'h6F};
    s0 = cyc;
    run_xfer(0, -1, -1, 1'b0);
    check("restart_latency", last_done - s0, 13);
    check("restart_b3", mem_b[3], 8'h6F);

`ifdef MEM_XFER_SKIP_ZERO_EN
    step();
    xw = '{8'h00, 8'h05, 8'h00, 8'h07};
    s0 = cyc;
    run_xfer(0, -1, -1, 1'b0);
    check("skip_latency", last_done - s0, 11);
    check("skip_b0", mem_b[0], 8'h05);
    check("skip_b1", mem_b[1], 8'h07);
    check("skip_countb", CountB, 2);
`endif

    step();
    check("queues_empty", exp_a.size() + exp_rd.size() + exp_b.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
